// File: rtl/banner_if.sv
// Banner scroller control/data bundle.
//   master: drives enable, dir, mode, step, load, load_data; observes digits, shift_pulse
//   slave : the scroller itself
interface banner_if #(
  parameter int NUM_DIGITS = 4
) ();
  logic                      enable;
  logic                      dir;
  logic [1:0]                mode;
  logic                      step;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   load_data;
  logic [4*NUM_DIGITS-1:0]   digits;
  logic                      shift_pulse;

  modport master (
    output enable, dir, mode, step, load, load_data,
    input  digits, shift_pulse
  );

  modport slave (
    input  enable, dir, mode, step, load, load_data,
    output digits, shift_pulse
  );
endinterface

// File: rtl/banner_scroller.sv
// banner_scroller: N-digit BCD banner for the seven-segment path.
// Shifts a row of 4-bit digits left/right on a 2**TICK_WIDTH timer tick or a
// single-step request, in COUNT / ROTATE / BOUNCE / HOLD modes, with a
// parallel load that replaces the whole row.
//   clk, reset      : clock, synchronous active-high reset
//   bus (slave)     : enable, dir, mode, step, load, load_data in;
//                     digits (digit i at [4i+3:4i]), shift_pulse out

// One digit position: picks its neighbour according to shift direction.
module banner_lane (
  input  logic [3:0] from_lower,  // digit i-1 (or fill for digit 0)
  input  logic [3:0] from_upper,  // digit i+1 (or fill for digit N-1)
  input  logic       shift_left,
  output logic [3:0] nxt
);
  assign nxt = shift_left ? from_lower : from_upper;
endmodule

module banner_scroller #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_WIDTH = 23
) (
  input  logic     clk,
  input  logic     reset,
  banner_if.slave  bus
);
  localparam logic [1:0] M_COUNT  = 2'b00;
  localparam logic [1:0] M_ROTATE = 2'b01;
  localparam logic [1:0] M_BOUNCE = 2'b10;
  localparam logic [1:0] M_HOLD   = 2'b11;
  localparam int         BW       = $clog2(NUM_DIGITS);

  typedef logic [NUM_DIGITS-1:0][3:0] row_t;

  // Reset pattern: digit i = (N-1-i) mod 10, e.g. 0x0123 for four digits.
  function automatic row_t reset_row();
    row_t r;
    for (int i = 0; i < NUM_DIGITS; i++) r[i] = 4'((NUM_DIGITS - 1 - i) % 10);
    return r;
  endfunction
  localparam row_t RST_ROW = reset_row();

  row_t                  digits_q;
  row_t                  nxt_row;
  logic [TICK_WIDTH-1:0] timer_q;
  logic                  pulse_q;
  logic                  dir_q;
  logic [BW-1:0]         bcnt_q;

  logic       tick;
  logic       shift_ev;
  logic       eff_left;
  logic [3:0] fill;
  logic [3:0] edge_lo, edge_hi;

  assign tick     = bus.enable && (&timer_q);
  assign shift_ev = (tick || bus.step) && (bus.mode != M_HOLD) && !bus.load;
  assign eff_left = (bus.mode == M_BOUNCE) ? dir_q : bus.dir;
  assign edge_lo  = digits_q[0];
  assign edge_hi  = digits_q[NUM_DIGITS-1];

  // COUNT fills with the incremented/decremented entering-side edge digit;
  // non-BCD edge digits restart the count at 0. Other modes rotate.
  always_comb begin
    fill = 4'd0;
    if (bus.mode == M_COUNT) begin
      if (eff_left) fill = (edge_lo >= 4'd9) ? 4'd0 : edge_lo + 4'd1;
      else          fill = (edge_hi > 4'd9) ? 4'd0 :
                           (edge_hi == 4'd0) ? 4'd9 : edge_hi - 4'd1;
    end else begin
      fill = eff_left ? edge_hi : edge_lo;
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lane
    logic [3:0] lo, hi;
    if (gi == 0) begin : g_lo_fill
      assign lo = fill;
    end else begin : g_lo_nb
      assign lo = digits_q[gi-1];
    end
    if (gi == NUM_DIGITS - 1) begin : g_hi_fill
      assign hi = fill;
    end else begin : g_hi_nb
      assign hi = digits_q[gi+1];
    end
    banner_lane u_lane (
      .from_lower (lo),
      .from_upper (hi),
      .shift_left (eff_left),
      .nxt        (nxt_row[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digits_q <= RST_ROW;
      timer_q  <= '0;
      pulse_q  <= 1'b0;
      dir_q    <= 1'b0;
      bcnt_q   <= '0;
    end else begin
      pulse_q <= shift_ev;

      if (bus.load)     digits_q <= row_t'(bus.load_data);
      else if (shift_ev) digits_q <= nxt_row;

      // Timer keeps running in HOLD; load restarts the phase.
      if (bus.load)        timer_q <= '0;
      else if (bus.enable) timer_q <= timer_q + TICK_WIDTH'(1);

      // Bounce direction tracks dir outside BOUNCE so entering BOUNCE
      // starts in the currently requested direction.
      if (bus.mode != M_BOUNCE) begin
        dir_q  <= bus.dir;
        bcnt_q <= '0;
      end else if (bus.load) begin
        bcnt_q <= '0;
      end else if (shift_ev) begin
        if (bcnt_q == BW'(NUM_DIGITS - 2)) begin
          bcnt_q <= '0;
          dir_q  <= ~dir_q;
        end else begin
          bcnt_q <= bcnt_q + BW'(1);
        end
      end
    end
  end

  assign bus.digits      = digits_q;
  assign bus.shift_pulse = pulse_q;
endmodule

// File: tb/tb_banner_scroller.sv
module tb_banner_scroller;
  localparam int N  = 4;
  localparam int TW = 3;
  localparam int PERIOD = 1 << TW;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_fail = 0;

  banner_if #(.NUM_DIGITS(N)) bif ();

  banner_scroller #(.NUM_DIGITS(N), .TICK_WIDTH(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Behavioural reference: digit array, timer phase, bounce state.
  int md[N];
  int mctr, mdirq, mbcnt;
  bit mpulse;

  function automatic logic [4*N-1:0] mpack();
    logic [4*N-1:0] v;
    for (int i = 0; i < N; i++) v[4*i +: 4] = 4'(md[i]);
    return v;
  endfunction

  // Advance model using current inputs, then clock the DUT.
  task automatic clk_step();
    int  nd[N];
    int  fill;
    bit  tk, sh, left;
    if (reset) begin
      for (int i = 0; i < N; i++) md[i] = (N - 1 - i) % 10;
      mctr = 0; mdirq = 0; mbcnt = 0; mpulse = 0;
    end else begin
      tk   = bif.enable && (mctr == PERIOD - 1);
      sh   = (tk || bif.step) && (bif.mode != 2'd3) && !bif.load;
      left = (bif.mode == 2'd2) ? mdirq[0] : bif.dir;
      if (bif.load) begin
        for (int i = 0; i < N; i++) md[i] = int'((bif.load_data >> (4*i)) & 16'hF);
      end else if (sh) begin
        if (bif.mode == 2'd0) begin
          if (left) fill = (md[0] > 9) ? 0 : (md[0] + 1) % 10;
          else      fill = (md[N-1] > 9) ? 0 : (md[N-1] + 9) % 10;
        end else begin
          fill = left ? md[N-1] : md[0];
        end
        for (int i = 0; i < N; i++) begin
          if (left) nd[i] = (i == 0)     ? fill : md[i-1];
          else      nd[i] = (i == N - 1) ? fill : md[i+1];
        end
        md = nd;
      end
      if (bif.mode != 2'd2) begin
        mdirq = int'(bif.dir); mbcnt = 0;
      end else if (bif.load) begin
        mbcnt = 0;
      end else if (sh) begin
        if (mbcnt == N - 2) begin mbcnt = 0; mdirq = 1 - mdirq; end
        else mbcnt++;
      end
      if (bif.load) mctr = 0;
      else if (bif.enable) mctr = (mctr + 1) % PERIOD;
      mpulse = sh;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bif.enable = 0; bif.dir = 0; bif.mode = 2'd0;
    bif.step = 0; bif.load = 0; bif.load_data = '0;
    clk_step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (bif.digits !== 16'h0123) begin
      n_fail++; $display("FAIL reset_digits: got %h want %h", bif.digits, 16'h0123);
    end
    n_cmp++;
    if (bif.shift_pulse !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulse: got %b want 0", bif.shift_pulse);
    end
  endtask

  task automatic test_timed_count();
    do_reset();
    bif.enable = 1; bif.dir = 1; bif.mode = 2'd0;
    for (int c = 1; c <= 2*PERIOD; c++) begin
      clk_step();
      n_cmp++;
      if (bif.digits !== mpack() || bif.shift_pulse !== mpulse) begin
        n_fail++; $display("FAIL timed_model c%0d: got %h/%b want %h/%b",
                           c, bif.digits, bif.shift_pulse, mpack(), mpulse);
      end
      if (c == PERIOD || c == 2*PERIOD) begin
        n_cmp++;
        if (bif.digits !== ((c == PERIOD) ? 16'h1234 : 16'h2345) || bif.shift_pulse !== 1'b1) begin
          n_fail++; $display("FAIL timed_edge%0d: got %h/%b want %h/1", c, bif.digits,
                             bif.shift_pulse, (c == PERIOD) ? 16'h1234 : 16'h2345);
        end
      end
    end
  endtask

  task automatic test_step_count();
    logic [15:0] exp_s[2];
    exp_s[0] = 16'h9012; exp_s[1] = 16'h8901;
    do_reset();
    bif.dir = 0; bif.step = 1;
    for (int k = 0; k < 2; k++) begin
      clk_step();
      n_cmp++;
      if (bif.digits !== exp_s[k] || bif.shift_pulse !== 1'b1) begin
        n_fail++; $display("FAIL count_step%0d: got %h/%b want %h/1", k, bif.digits, bif.shift_pulse, exp_s[k]);
      end
    end
    bif.step = 0; bif.load = 1; bif.load_data = 16'hF000;
    clk_step();
    bif.load = 0; bif.dir = 1; bif.step = 1;
    clk_step();
    bif.step = 0;
    n_cmp++;
    if (bif.digits !== 16'h0001) begin
      n_fail++; $display("FAIL count_nonbcd: got %h want %h", bif.digits, 16'h0001);
    end
  endtask

  task automatic test_rotate();
    logic [15:0] exp_r[4];
    exp_r[0] = 16'h1230; exp_r[1] = 16'h2301; exp_r[2] = 16'h3012; exp_r[3] = 16'h0123;
    do_reset();
    bif.mode = 2'd1; bif.dir = 1; bif.step = 1;
    for (int k = 0; k < 4; k++) begin
      clk_step();
      n_cmp++;
      if (bif.digits !== exp_r[k]) begin
        n_fail++; $display("FAIL rotate%0d: got %h want %h", k, bif.digits, exp_r[k]);
      end
    end
    bif.step = 0;
  endtask

  task automatic test_bounce();
    logic [15:0] exp_b[6];
    exp_b[0] = 16'h1230; exp_b[1] = 16'h2301; exp_b[2] = 16'h3012;
    exp_b[3] = 16'h2301; exp_b[4] = 16'h1230; exp_b[5] = 16'h0123;
    do_reset();
    bif.dir = 1;
    clk_step();               // let the bounce direction pick up dir
    bif.mode = 2'd2; bif.step = 1;
    for (int k = 0; k < 6; k++) begin
      clk_step();
      n_cmp++;
      if (bif.digits !== exp_b[k]) begin
        n_fail++; $display("FAIL bounce%0d: got %h want %h", k, bif.digits, exp_b[k]);
      end
    end
    bif.step = 0;
  endtask

  task automatic test_hold();
    int bad;
    do_reset();
    bif.mode = 2'd3; bif.enable = 1; bif.step = 1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      clk_step();
      if (bif.digits !== 16'h0123 || bif.shift_pulse !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++; $display("FAIL hold_frozen: got %0d bad cycles want 0 (last %h/%b)", bad, bif.digits, bif.shift_pulse);
    end
    bif.load = 1; bif.load_data = 16'h5678;
    clk_step();
    bif.load = 0;
    n_cmp++;
    if (bif.digits !== 16'h5678) begin
      n_fail++; $display("FAIL hold_load: got %h want %h", bif.digits, 16'h5678);
    end
    bif.step = 0;
  endtask

  task automatic test_load_tick();
    int bad;
    do_reset();
    bif.enable = 1; bif.dir = 1; bif.mode = 2'd0;
    for (int k = 0; k < PERIOD - 1; k++) clk_step();
    bif.load = 1; bif.load_data = 16'hABCD;   // coincides with the tick
    clk_step();
    bif.load = 0;
    n_cmp++;
    if (bif.digits !== 16'hABCD || bif.shift_pulse !== 1'b0) begin
      n_fail++; $display("FAIL load_tick: got %h/%b want abcd/0", bif.digits, bif.shift_pulse);
    end
    bad = 0;
    for (int k = 0; k < PERIOD - 1; k++) begin
      clk_step();
      if (bif.shift_pulse !== 1'b0) bad++;
    end
    clk_step();
    n_cmp++;
    if (bad != 0 || bif.shift_pulse !== 1'b1 || bif.digits !== 16'hBCD0) begin
      n_fail++; $display("FAIL load_phase: got early=%0d %h/%b want early=0 bcd0/1", bad, bif.digits, bif.shift_pulse);
    end
    reset = 1; bif.load = 1; bif.step = 1;
    clk_step();
    reset = 0; bif.load = 0; bif.step = 0;
    n_cmp++;
    if (bif.digits !== 16'h0123 || bif.shift_pulse !== 1'b0) begin
      n_fail++; $display("FAIL reset_over_load: got %h/%b want 0123/0", bif.digits, bif.shift_pulse);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      reset          = ($urandom_range(0, 99) == 0);
      bif.enable     = ($urandom_range(0, 3) != 0);
      bif.dir        = 1'($urandom_range(0, 1));
      bif.mode       = 2'($urandom_range(0, 3));
      bif.step       = ($urandom_range(0, 3) == 0);
      bif.load       = ($urandom_range(0, 15) == 0);
      bif.load_data  = 16'($urandom);
      clk_step();
      n_cmp++;
      if (bif.digits !== mpack() || bif.shift_pulse !== mpulse) begin
        n_fail++; $display("FAIL random c%0d: got %h/%b want %h/%b",
                           c, bif.digits, bif.shift_pulse, mpack(), mpulse);
      end
    end
    reset = 0;
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_timed_count();
    test_step_count();
    test_rotate();
    test_bounce();
    test_hold();
    test_load_tick();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
